// File: rtl/multicycle_alu.sv
// Execute-stage ALU: operand muxes, single-cycle ops, iterative MULU/DIVU into HI/LO.
// Define MULTICYCLE_ALU_DIV_EN to build the restoring divider for DIVU.
module multicycle_alu #(
  parameter int WIDTH  = 32,
  parameter int IMM_W  = 16,
  parameter int JUMP_W = 26,
  parameter int PC_INC = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  pc_out,
  input  logic [JUMP_W-1:0] jump_address,
  input  logic [IMM_W-1:0]  immediate,
  input  logic [WIDTH-1:0]  read_data1,
  input  logic [WIDTH-1:0]  read_data2,
  input  logic              alusrcA,
  input  logic [1:0]        alusrcB,
  input  logic [3:0]        alu_control,
  input  logic              start,
  output logic [WIDTH-1:0]  alu_result,
  output logic [WIDTH-1:0]  alu_out,
  output logic              zero_flag,
  output logic [WIDTH-1:0]  sign_extend,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] jump_target;
  logic             unused_pc_low;

  assign sign_extend = {{(WIDTH-IMM_W){immediate[IMM_W-1]}}, immediate};
  assign jump_target = {pc_out[WIDTH-1:JUMP_W+2], jump_address, 2'b00};
  assign unused_pc_low = ^pc_out[JUMP_W+1:0];
  assign src_a = alusrcA ? read_data1 : pc_out;

  always_comb begin
    src_b = read_data2;
    unique case (alusrcB)
      2'b00: src_b = read_data2;
      2'b01: src_b = WIDTH'(PC_INC);
      2'b10: src_b = sign_extend;
      2'b11: src_b = jump_target;
    endcase
  end

  always_comb begin
    alu_result = '0;
    case (alu_control)
      OP_AND: alu_result = src_a & src_b;
      OP_OR:  alu_result = src_a | src_b;
      OP_ADD: alu_result = src_a + src_b;
      OP_SUB: alu_result = src_a - src_b;
      OP_SLT: alu_result = {{(WIDTH-1){1'b0}},
                            $signed(src_a) < $signed(src_b)};
      OP_NOR: alu_result = ~(src_a | src_b);
      default: alu_result = '0;
    endcase
  end

  assign zero_flag = (alu_result == '0);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] nx_hi;
  logic [WIDTH-1:0] nx_lo;
  logic             launch_op;
  logic [WIDTH:0]   mul_sum;

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // acc_lo holds the multiplier (MULU) or the dividend/quotient (DIVU)
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);

`ifdef MULTICYCLE_ALU_DIV_EN
  logic           is_div;
  logic [WIDTH:0] shl;

  assign launch_op = (alu_control == OP_MULU) ||
                     (alu_control == OP_DIVU);
  assign shl = {acc_hi, acc_lo[WIDTH-1]};

  always_comb begin
    nx_hi = mul_sum[WIDTH:1];
    nx_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    if (is_div) begin
      if (shl >= {1'b0, opb}) begin
        nx_hi = WIDTH'(shl - {1'b0, opb});
        nx_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        nx_hi = shl[WIDTH-1:0];
        nx_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end
  end
`else
  assign launch_op = (alu_control == OP_MULU);

  always_comb begin
    nx_hi = mul_sum[WIDTH:1];
    nx_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_out <= '0;
      hi      <= '0;
      lo      <= '0;
      state   <= IDLE;
      cnt     <= '0;
      opb     <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
`ifdef MULTICYCLE_ALU_DIV_EN
      is_div  <= 1'b0;
`endif
    end else begin
      alu_out <= alu_result;
      case (state)
        IDLE: begin
          if (start && launch_op) begin
            state  <= RUN;
            cnt    <= CW'(WIDTH-1);
            acc_hi <= '0;
            acc_lo <= src_a;
            opb    <= src_b;
`ifdef MULTICYCLE_ALU_DIV_EN
            is_div <= (alu_control == OP_DIVU);
`endif
          end
        end
        RUN: begin
          acc_hi <= nx_hi;
          acc_lo <= nx_lo;
          cnt    <= cnt - 1'b1;
          if (cnt == '0) begin
            state <= DONE;
            hi    <= nx_hi;
            lo    <= nx_lo;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Randomized self-checking bench for multicycle_alu against an arithmetic model.
// DIVU checks follow MULTICYCLE_ALU_DIV_EN.
module tb_multicycle_alu;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  pc_out;
  logic [25:0]   jump_address;
  logic [15:0]   immediate;
  logic [W-1:0]  read_data1;
  logic [W-1:0]  read_data2;
  logic          alusrcA;
  logic [1:0]    alusrcB;
  logic [3:0]    alu_control;
  logic          start;
  logic [W-1:0]  alu_result;
  logic [W-1:0]  alu_out;
  logic          zero_flag;
  logic [W-1:0]  sign_extend;
  logic          busy;
  logic          done;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  int n_cmp = 0;
  int n_bad = 0;

  multicycle_alu dut (
    .clk(clk), .reset(reset), .pc_out(pc_out),
    .jump_address(jump_address), .immediate(immediate),
    .read_data1(read_data1), .read_data2(read_data2),
    .alusrcA(alusrcA), .alusrcB(alusrcB),
    .alu_control(alu_control), .start(start),
    .alu_result(alu_result), .alu_out(alu_out),
    .zero_flag(zero_flag), .sign_extend(sign_extend),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] m_sext(input logic [15:0] im);
    return im[15] ? 32'hFFFF_0000 + 32'(im) : 32'(im);
  endfunction

  function automatic logic [W-1:0] m_a();
    return alusrcA ? read_data1 : pc_out;
  endfunction

  function automatic logic [W-1:0] m_b();
    case (alusrcB)
      2'd0:    return read_data2;
      2'd1:    return 32'd1;
      2'd2:    return m_sext(immediate);
      default: return (pc_out & 32'hF000_0000) + 32'(jump_address) * 4;
    endcase
  endfunction

  function automatic logic [W-1:0] m_alu(input logic [3:0] op,
                                         input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd6:    return a - b;
      4'd7:    return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd12:   return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_comb(input string tag);
    logic [W-1:0] exp;
    #1;
    exp = m_alu(alu_control, m_a(), m_b());
    check({tag, "_res"}, 64'(alu_result), 64'(exp));
    check({tag, "_zero"}, 64'(zero_flag), 64'(exp == 0));
    check({tag, "_sext"}, 64'(sign_extend), 64'(m_sext(immediate)));
    tick();
    check({tag, "_out"}, 64'(alu_out), 64'(exp));
  endtask

  task automatic run_op(input logic [3:0] op,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b);
    logic [63:0] exp;
    int cyc;
    if (op == 4'b1000) exp = 64'(a) * 64'(b);
    else if (b == 0) exp = {a, 32'hFFFF_FFFF};
    else exp = {a % b, a / b};
    alusrcA = 1'b1;
    alusrcB = 2'b00;
    read_data1 = a;
    read_data2 = b;
    alu_control = op;
    start = 1'b1;
    #1;
    check("mc_res_zero", 64'(alu_result), 64'd0);
    tick();
    start = 1'b0;
    check("mc_busy", 64'(busy), 64'd1);
    cyc = 0;
    while (!done && cyc < 100) begin
      if (cyc == 5) begin
        start = 1'b1;
        read_data1 = $urandom;
        read_data2 = $urandom;
      end else begin
        start = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    check("mc_latency", 64'(cyc), 64'(W));
    check("mc_busy_done", 64'(busy), 64'd0);
    check("mc_hilo", {hi, lo}, exp);
    tick();
    check("mc_done_pulse", 64'(done), 64'd0);
    check("mc_hold", {hi, lo}, exp);
  endtask

  initial begin
    logic [3:0] ops [9];
    int seen;
    ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd8, 4'd9, 4'd5};
    reset = 1'b1;
    pc_out = '0;
    jump_address = '0;
    immediate = '0;
    read_data1 = '0;
    read_data2 = '0;
    alusrcA = 1'b0;
    alusrcB = 2'b00;
    alu_control = 4'd0;
    start = 1'b0;
    tick();
    tick();
    check("rst_alu_out", 64'(alu_out), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    reset = 1'b0;
    tick();

    alusrcA = 1'b1;
    read_data1 = 32'd7;
    read_data2 = 32'd7;
    alu_control = 4'd6;
    check_comb("sub_eq");

    alusrcA = 1'b0;
    alusrcB = 2'b11;
    pc_out = 32'h4000_0000;
    jump_address = 26'h10;
    alu_control = 4'd2;
    #1;
    check("jump_add", 64'(alu_result), 64'h8000_0040);
    check_comb("jump");

    alusrcA = 1'b1;
    alusrcB = 2'b00;
    read_data1 = 32'hFFFF_FFFF;
    read_data2 = 32'd1;
    alu_control = 4'd7;
    immediate = 16'h8000;
    #1;
    check("slt_neg", 64'(alu_result), 64'd1);
    check("sext_8000", 64'(sign_extend), 64'hFFFF_8000);
    check_comb("slt");

    for (int i = 0; i < 40; i++) begin
      alusrcA = 1'($urandom);
      alusrcB = 2'($urandom);
      pc_out = $urandom;
      jump_address = 26'($urandom);
      immediate = 16'($urandom);
      read_data1 = (i % 5 == 0) ? 32'h8000_0000 : $urandom;
      read_data2 = (i % 7 == 0) ? read_data1 : $urandom;
      alu_control = ops[$urandom_range(0, 8)];
      check_comb("rand");
    end

    run_op(4'b1000, 32'hFFFF_FFFF, 32'd2);
    check("mul_dir", {hi, lo}, 64'h1_FFFF_FFFE);
    for (int i = 0; i < 4; i++) run_op(4'b1000, $urandom, $urandom);
    run_op(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

`ifdef MULTICYCLE_ALU_DIV_EN
    run_op(4'b1001, 32'd100, 32'd7);
    check("div_dir", {hi, lo}, {32'd2, 32'd14});
    run_op(4'b1001, 32'd100, 32'd0);
    check("div_zero", {hi, lo}, {32'd100, 32'hFFFF_FFFF});
    for (int i = 0; i < 4; i++)
      run_op(4'b1001, $urandom, 32'($urandom_range(1, 70000)));
    run_op(4'b1001, $urandom, $urandom);
`else
    alusrcA = 1'b1;
    alusrcB = 2'b00;
    alu_control = 4'b1001;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("divu_off_busy", 64'(busy), 64'd0);
    check("divu_off_res", 64'(alu_result), 64'd0);
    seen = 0;
    for (int i = 0; i < W + 3; i++) begin
      if (done || busy) seen++;
      tick();
    end
    check("divu_off_idle", 64'(seen), 64'd0);
`endif

    run_op(4'b1000, 32'h1234_5678, 32'h9ABC_DEF0);
    alu_control = 4'b1000;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_hilo", {hi, lo}, 64'd0);
    tick();
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < W + 5; i++) begin
      if (done || busy) seen++;
      tick();
    end
    check("mid_rst_quiet", 64'(seen), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
